synth_cfg_sequencer: RTL and testbench



---
 rtl/synth_cfg_pkg.sv | 43 ++++
 rtl/synth_cfg_sequencer_if.sv | 23 ++
 rtl/synth_cfg_sequencer_glide_stepper.sv | 47 ++++
 rtl/synth_cfg_sequencer.sv | 136 +++++++++++++
 tb/tb_synth_cfg_sequencer.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/synth_cfg_pkg.sv
// Shared constants and types for the synth voice-config sequencer.
package synth_cfg_pkg;

  localparam int unsigned WORD_W    = 16;
  localparam int unsigned NUM_SLOTS = 3;
  localparam int unsigned CFG_W     = WORD_W * NUM_SLOTS;
  localparam int unsigned PITCH_W   = 12;
  localparam int unsigned DIV_W     = 8;
  localparam int unsigned ADDR_W    = 3;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned PHASE_W   = 2;
  localparam int unsigned RATE_W    = 4;

  localparam logic [ADDR_W-1:0] ADDR_CTRL = 3'd6;
  localparam logic [ADDR_W-1:0] ADDR_RSVD = 3'd7;

  localparam int unsigned CTRL_COMMIT_BIT = 0;
  localparam int unsigned CTRL_GLIDE_BIT  = 1;
  localparam int unsigned CTRL_RATE_LSB   = 4;

  localparam logic [PHASE_W-1:0] FB_PHASE = 2'd3;

  localparam logic [WORD_W-1:0] DEF_SAW  = 16'h0638;
  localparam logic [WORD_W-1:0] DEF_OSC  = 16'h0638;
  localparam logic [WORD_W-1:0] DEF_DAMP = 16'h0838;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } commit_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] damp;
    logic [WORD_W-1:0] osc;
    logic [WORD_W-1:0] saw;
  } cfg_t;

  // Divider reload for a glide rate: rate*16 frames between ticks (plus the tick frame).
  function automatic logic [DIV_W-1:0] div_reload(input logic [RATE_W-1:0] rate);
    return DIV_W'({rate, 4'h0});
  endfunction

endpackage

// File: rtl/synth_cfg_sequencer_if.sv
// Host write port plus live-config/status outputs of the config sequencer.
interface synth_cfg_if;
  import synth_cfg_pkg::*;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  cfg_t              cfg_out;
  logic              commit_pending;
  logic              gliding;

  modport master (
    output wr_valid, wr_addr, wr_data,
    input  wr_ready, cfg_out, commit_pending, gliding
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data,
    output wr_ready, cfg_out, commit_pending, gliding
  );

endinterface

// File: rtl/synth_cfg_sequencer_glide_stepper.sv
// Live/target pitch pair for one slot; steps live one LSB toward target per tick.
module glide_stepper #(
  parameter int unsigned             PITCH_BITS = 12,
  parameter logic [PITCH_BITS-1:0]   RST_PITCH  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  glide_en,
  input  logic                  tick,
  input  logic [PITCH_BITS-1:0] load_pitch,
  output logic [PITCH_BITS-1:0] live_pitch,
  output logic                  mismatch_c
);

  logic [PITCH_BITS-1:0] live_q, tgt_q;
  logic [PITCH_BITS-1:0] live_d, tgt_d, base_c;

  // Target updates first so a tick in the same edge steps toward the new target.
  always_comb begin
    tgt_d  = tgt_q;
    base_c = live_q;
    if (load) begin
      tgt_d = load_pitch;
      if (!glide_en) base_c = load_pitch;
    end
    live_d = base_c;
    if (tick) begin
      if (base_c < tgt_d)      live_d = base_c + PITCH_BITS'(1);
      else if (base_c > tgt_d) live_d = base_c - PITCH_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      live_q <= RST_PITCH;
      tgt_q  <= RST_PITCH;
    end else begin
      live_q <= live_d;
      tgt_q  <= tgt_d;
    end
  end

  assign live_pitch = live_q;
  assign mismatch_c = (live_q != tgt_q);

endmodule

// File: rtl/synth_cfg_sequencer.sv
// Shadow/live voice-config sequencer: host byte writes, frame-aligned commit, optional glide.
module synth_cfg_sequencer
  import synth_cfg_pkg::*;
#(
  parameter int unsigned          WORD_BITS  = WORD_W,
  parameter int unsigned          PITCH_BITS = PITCH_W,
  parameter int unsigned          DIV_BITS   = DIV_W,
  parameter logic [WORD_BITS-1:0] RST_SAW    = DEF_SAW,
  parameter logic [WORD_BITS-1:0] RST_OSC    = DEF_OSC,
  parameter logic [WORD_BITS-1:0] RST_DAMP   = DEF_DAMP
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PHASE_W-1:0] phase,
  synth_cfg_if.slave         bus
);

  localparam int unsigned UPPER_BITS = WORD_BITS - PITCH_BITS;
  localparam logic [NUM_SLOTS*WORD_BITS-1:0] RST_CFG = {RST_DAMP, RST_OSC, RST_SAW};

  logic [WORD_BITS-1:0]  shadow_q  [NUM_SLOTS];
  logic [UPPER_BITS-1:0] live_hi_q [NUM_SLOTS];
  logic [PITCH_BITS-1:0] live_pitch [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]  mismatch_c;
  logic [NUM_SLOTS*WORD_BITS-1:0] cfg_c;

  logic              glide_en_q;
  logic [RATE_W-1:0] rate_q;
  logic [DIV_BITS-1:0] div_q;
  logic              pending_q, ready_q, gliding_q;
  commit_state_e     state_q, state_d;
  logic              apply_c;

  logic wr_fire_c, ctrl_wr_c, shadow_wr_c, commit_req_c, fb_c, tick_c;

  assign wr_fire_c    = bus.wr_valid && ready_q;
  assign ctrl_wr_c    = wr_fire_c && (bus.wr_addr == ADDR_CTRL);
  assign shadow_wr_c  = wr_fire_c && (bus.wr_addr != ADDR_CTRL) && (bus.wr_addr != ADDR_RSVD);
  assign commit_req_c = ctrl_wr_c && bus.wr_data[CTRL_COMMIT_BIT];
  assign fb_c         = (phase == FB_PHASE);
  assign tick_c       = fb_c && glide_en_q && (div_q == '0);

  // Shadow register file, byte addressed.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NUM_SLOTS; s++) shadow_q[s] <= RST_CFG[s*WORD_BITS +: WORD_BITS];
    end else if (shadow_wr_c) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (bus.wr_addr[ADDR_W-1:1] == (ADDR_W-1)'(s)) begin
          if (bus.wr_addr[0]) shadow_q[s][WORD_BITS-1:DATA_W] <= bus.wr_data;
          else                shadow_q[s][DATA_W-1:0]         <= bus.wr_data;
        end
      end
    end
  end

  // Control fields; the commit bit is consumed by the FSM and never stored.
  always_ff @(posedge clk) begin
    if (reset) begin
      glide_en_q <= 1'b0;
      rate_q     <= '0;
    end else if (ctrl_wr_c) begin
      glide_en_q <= bus.wr_data[CTRL_GLIDE_BIT];
      rate_q     <= bus.wr_data[CTRL_RATE_LSB +: RATE_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    apply_c = 1'b0;
    case (state_q)
      ST_IDLE:    if (commit_req_c) state_d = ST_PENDING;
      ST_PENDING: if (fb_c) begin
        apply_c = 1'b1;
        state_d = ST_IDLE;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= 1'b0;
      ready_q   <= 1'b1;
      gliding_q <= 1'b0;
    end else begin
      pending_q <= (state_d == ST_PENDING);
      ready_q   <= (state_d != ST_PENDING);
      gliding_q <= |mismatch_c;
    end
  end

  // Glide tick divider, advanced once per frame and parked at zero while glide is off.
  always_ff @(posedge clk) begin
    if (reset || !glide_en_q) div_q <= '0;
    else if (fb_c)            div_q <= (div_q == '0) ? div_reload(rate_q) : div_q - DIV_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NUM_SLOTS; s++)
        live_hi_q[s] <= RST_CFG[s*WORD_BITS+PITCH_BITS +: UPPER_BITS];
    end else if (apply_c) begin
      for (int s = 0; s < NUM_SLOTS; s++)
        live_hi_q[s] <= shadow_q[s][WORD_BITS-1:PITCH_BITS];
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    glide_stepper #(
      .PITCH_BITS (PITCH_BITS),
      .RST_PITCH  (RST_CFG[g*WORD_BITS +: PITCH_BITS])
    ) u_step (
      .clk        (clk),
      .reset      (reset),
      .load       (apply_c),
      .glide_en   (glide_en_q),
      .tick       (tick_c),
      .load_pitch (shadow_q[g][PITCH_BITS-1:0]),
      .live_pitch (live_pitch[g]),
      .mismatch_c (mismatch_c[g])
    );
    assign cfg_c[g*WORD_BITS +: WORD_BITS] = {live_hi_q[g], live_pitch[g]};
  end

  assign bus.cfg_out        = cfg_t'(cfg_c);
  assign bus.wr_ready       = ready_q;
  assign bus.commit_pending = pending_q;
  assign bus.gliding        = gliding_q;

endmodule

// File: tb/tb_synth_cfg_sequencer.sv
// Scoreboard bench for synth_cfg_sequencer: directed writes, expected cfg_out transitions queued.
module tb_synth_cfg_sequencer;
  import synth_cfg_pkg::*;

  localparam logic [47:0] CFG_RST = 48'h0838_0638_0638;

  typedef struct {
    logic [47:0] cfg;
    bit          chk_phase;
    int          gap;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] phase;
  int         errors = 0;
  int         checks = 0;
  int         cyc    = 0;
  bit         mon_en = 1'b0;
  exp_t       exp_q[$];

  synth_cfg_if bus ();

  synth_cfg_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .phase (phase),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin : phase_gen
    phase = 2'd0;
    forever begin
      @(negedge clk);
      phase = phase + 2'd1;
    end
  end

  initial begin : cyc_count
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void push(input logic [47:0] c, input bit ph, input int g);
    exp_t e;
    e.cfg       = c;
    e.chk_phase = ph;
    e.gap       = g;
    exp_q.push_back(e);
  endfunction

  // Monitor: every cfg_out transition must match the next queued expectation.
  initial begin : monitor
    logic [47:0] last;
    int          last_cyc;
    exp_t        e;
    wait (mon_en);
    last     = CFG_RST;
    last_cyc = cyc;
    forever begin
      @(posedge clk);
      #1;
      if (bus.cfg_out !== last) begin
        if (exp_q.size() == 0) begin
          check("unexpected_cfg_change", bus.cfg_out, last);
        end else begin
          e = exp_q.pop_front();
          check("cfg_value", bus.cfg_out, e.cfg);
          if (e.chk_phase) check("cfg_at_frame_boundary", phase, 2'd3);
          if (e.gap != 0) check("cfg_step_gap", cyc - last_cyc, e.gap);
        end
        last     = bus.cfg_out;
        last_cyc = cyc;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d, output int stalls);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    stalls       = 0;
    while (!bus.wr_ready && stalls < 100) begin
      step();
      stalls++;
    end
    if (!bus.wr_ready) check("write_accept_timeout", 64'(bus.wr_ready), 64'd1);
    @(posedge clk);
    step();
    bus.wr_valid = 1'b0;
  endtask

  task automatic w(input logic [2:0] a, input logic [7:0] d);
    int s;
    wr(a, d, s);
  endtask

  task automatic wait_phase(input logic [1:0] p);
    int n = 0;
    while (phase != p && n < 8) begin
      step();
      n++;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.commit_pending && n < 20) begin
      step();
      n++;
    end
    check("commit_cleared", 64'(bus.commit_pending), 64'd0);
  endtask

  // Waits (sampling just after posedge) for a slot word to reach a value.
  task automatic wait_slot(input int slot, input logic [15:0] val, input int bound, output bit hit);
    logic [47:0] c;
    hit = 1'b0;
    for (int n = 0; n < bound && !hit; n++) begin
      @(posedge clk);
      #1;
      c = bus.cfg_out;
      if (c[slot*16 +: 16] == val) hit = 1'b1;
    end
  endtask

  initial begin : stim
    int          stalls;
    bit          hit;
    int          lat;
    logic [47:0] c;

    reset        = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    repeat (3) step();
    reset = 1'b0;
    repeat (2) step();

    check("reset_cfg", bus.cfg_out, CFG_RST);
    check("reset_wr_ready", 64'(bus.wr_ready), 64'd1);
    check("reset_gliding", 64'(bus.gliding), 64'd0);
    check("reset_pending", 64'(bus.commit_pending), 64'd0);
    mon_en = 1'b1;
    step();

    // Basic commit accepted at phase 1
    w(3'd0, 8'h40);
    w(3'd1, 8'h07);
    wait_phase(2'd1);
    push(48'h0838_0638_0740, 1'b1, 0);
    w(3'd6, 8'h01);
    check("pending_after_commit", 64'(bus.commit_pending), 64'd1);
    check("ready_low_while_pending", 64'(bus.wr_ready), 64'd0);
    check("cfg_held_before_fb", bus.cfg_out, CFG_RST);
    wait_idle();
    check("cfg_after_commit", bus.cfg_out, 48'h0838_0638_0740);
    check("ready_after_commit", 64'(bus.wr_ready), 64'd1);

    // Write during pending stalls, then lands with its own data
    push(48'h0838_0611_0740, 1'b1, 0);
    w(3'd2, 8'h11);
    w(3'd6, 8'h01);
    wr(3'd3, 8'h07, stalls);
    check("stalled_write_waited", 64'(stalls > 0), 64'd1);
    check("stalled_write_not_live", bus.cfg_out, 48'h0838_0611_0740);
    push(48'h0838_0711_0740, 1'b1, 0);
    w(3'd6, 8'h01);
    wait_idle();

    // Glide rate 0: slot1 0638 -> 063C, one step per frame
    push(48'h0838_0638_0740, 1'b1, 0);
    w(3'd2, 8'h38);
    w(3'd3, 8'h06);
    w(3'd6, 8'h01);
    wait_idle();
    push(48'h0838_0639_0740, 1'b1, 0);
    push(48'h0838_063A_0740, 1'b1, 4);
    push(48'h0838_063B_0740, 1'b1, 4);
    push(48'h0838_063C_0740, 1'b1, 4);
    w(3'd2, 8'h3C);
    w(3'd6, 8'h03);
    wait_slot(1, 16'h063C, 100, hit);
    check("glide_reached_target", 64'(hit), 64'd1);
    check("gliding_lags_last_step", 64'(bus.gliding), 64'd1);
    @(posedge clk);
    #1;
    check("gliding_falls", 64'(bus.gliding), 64'd0);
    repeat (12) step();

    // Glide across an octave boundary at rate 1
    push(48'h0838_05FF_0740, 1'b1, 0);
    w(3'd2, 8'hFF);
    w(3'd3, 8'h05);
    w(3'd6, 8'h01);
    wait_idle();
    push(48'h0838_0600_0740, 1'b1, 0);
    push(48'h0838_0601_0740, 1'b1, 68);
    w(3'd2, 8'h01);
    w(3'd3, 8'h06);
    w(3'd6, 8'h13);
    wait_slot(1, 16'h0601, 200, hit);
    check("octave_glide_done", 64'(hit), 64'd1);
    repeat (8) step();
    check("octave_glide_idle", 64'(bus.gliding), 64'd0);

    // Commit accepted in a frame-boundary cycle applies 4 edges later
    w(3'd4, 8'h55);
    wait_phase(2'd3);
    push(48'h0855_0601_0740, 1'b1, 0);
    w(3'd6, 8'h01);
    lat = 0;
    hit = 1'b0;
    while (!hit && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      c = bus.cfg_out;
      if (c[47:32] == 16'h0855) hit = 1'b1;
    end
    check("fb_commit_latency", 64'(lat), 64'd4);
    step();

    // Reset in the middle of a glide restores defaults
    push(48'h0855_0601_0741, 1'b1, 0);
    push(48'h0855_0601_0742, 1'b1, 4);
    w(3'd0, 8'h50);
    w(3'd6, 8'h03);
    wait_slot(0, 16'h0742, 100, hit);
    check("glide_mid_progress", 64'(hit), 64'd1);
    step();
    check("gliding_mid_glide", 64'(bus.gliding), 64'd1);
    push(CFG_RST, 1'b0, 0);
    reset = 1'b1;
    step();
    check("midglide_reset_cfg", bus.cfg_out, CFG_RST);
    check("midglide_reset_gliding", 64'(bus.gliding), 64'd0);
    check("midglide_reset_ready", 64'(bus.wr_ready), 64'd1);
    reset = 1'b0;
    repeat (40) step();
    check("post_reset_stable", bus.cfg_out, CFG_RST);
    check("post_reset_gliding", 64'(bus.gliding), 64'd0);

    for (int n = 0; n < 100 && exp_q.size() != 0; n++) step();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
